// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared constants for the ID/EX stage: control-word layout, bubble encoding
// and the hard-wired zero register.
package id_ex_hazard_stage_pkg;
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 3;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
    localparam int    REG_ZERO    = 0;
endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage, bundled.
interface id_ex_hazard_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    import id_ex_hazard_stage_pkg::*;

    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    ctrl_t             id_ctrl;
    logic              id_valid;
    logic              flush;
    logic              mem_wait;
    logic              stall;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    ctrl_t             ex_ctrl;
    logic              ex_valid;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    modport slave (
        input  id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_ctrl, id_valid, flush, mem_wait,
        output stall, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               ex_ctrl, ex_valid, bubble_cnt, flush_cnt
    );

    modport master (
        output id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_ctrl, id_valid, flush, mem_wait,
        input  stall, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               ex_ctrl, ex_valid, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// Load-use hazard: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    output logic             hz_o
);
    logic rs_match, rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
    // r0 is hard-wired, so a load "into" it never produces a value to wait for
    assign hz_o = ex_valid_i & ex_memread_i & (ex_rt_i != REG_W'(REG_ZERO)) &
                  id_valid_i & (rs_match | rt_match);
endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall/bubble, branch flush, memory-wait
// freeze and saturating hazard statistics.
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_hazard_stage_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  bub_cnt_q, bub_cnt_d, fl_cnt_q, fl_cnt_d;
    logic              hz;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
        .ex_rt_i      (rt_q),
        .id_valid_i   (bus.id_valid),
        .id_rs_i      (bus.id_rs),
        .id_rt_i      (bus.id_rt),
        .id_uses_rt_i (bus.id_uses_rt),
        .hz_o         (hz)
    );

    // A flushed ID instruction is discarded anyway; during mem_wait the whole pipe is frozen.
    assign bus.stall = hz & ~bus.flush & ~bus.mem_wait;

    always_comb begin
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        bub_cnt_d = bub_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        if (bus.mem_wait) begin
            // hold everything
        end else if (bus.flush || hz) begin
            // all-zero bubble keeps the forwarding unit from matching on it
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            ctrl_d    = CTRL_BUBBLE;
            valid_d   = 1'b0;
            if (bus.flush) begin
                if (bus.id_valid && fl_cnt_q != CNT_MAX) fl_cnt_d = fl_cnt_q + CNT_ONE;
            end else if (bub_cnt_q != CNT_MAX) begin
                bub_cnt_d = bub_cnt_q + CNT_ONE;
            end
        end else begin
            rs_d      = bus.id_rs;
            rt_d      = bus.id_rt;
            rd_d      = bus.id_rd;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
            imm_d     = bus.id_imm;
            ctrl_d    = bus.id_valid ? bus.id_ctrl : CTRL_BUBBLE;
            valid_d   = bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            bub_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            bub_cnt_q <= bub_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    assign bus.ex_rs      = rs_q;
    assign bus.ex_rt      = rt_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_rs_data = rs_data_q;
    assign bus.ex_rt_data = rt_data_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_ctrl    = ctrl_q;
    assign bus.ex_valid   = valid_q;
    assign bus.bubble_cnt = bub_cnt_q;
    assign bus.flush_cnt  = fl_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed table-driven bench for id_ex_hazard_stage, plus a narrow-counter
// instance sharing the same stimulus for the saturation corner.
module tb_id_ex_hazard_stage;
    import id_ex_hazard_stage_pkg::*;

    localparam logic [8:0] C_LW   = 9'h1B0;  // regwrite memread memtoreg alusrc
    localparam logic [8:0] C_ADD  = 9'h10A;  // regwrite regdst aluop=010
    localparam logic [8:0] C_ADDI = 9'h110;  // regwrite alusrc

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  ctrl;
        logic        valid;
    } id_t;

    typedef struct {
        logic        rst, flush, mw;
        id_t         in;
        logic        stall;
        id_t         ex;
        logic [15:0] bub, fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();
    id_ex_hazard_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus_s ();

    id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
    id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s.slave));

    assign bus_s.id_rs      = bus.id_rs;
    assign bus_s.id_rt      = bus.id_rt;
    assign bus_s.id_rd      = bus.id_rd;
    assign bus_s.id_uses_rt = bus.id_uses_rt;
    assign bus_s.id_rs_data = bus.id_rs_data;
    assign bus_s.id_rt_data = bus.id_rt_data;
    assign bus_s.id_imm     = bus.id_imm;
    assign bus_s.id_ctrl    = bus.id_ctrl;
    assign bus_s.id_valid   = bus.id_valid;
    assign bus_s.flush      = bus.flush;
    assign bus_s.mem_wait   = bus.mem_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic mw, input id_t v);
        rst             = r;
        bus.flush       = fl;
        bus.mem_wait    = mw;
        bus.id_rs       = v.rs;
        bus.id_rt       = v.rt;
        bus.id_rd       = v.rd;
        bus.id_uses_rt  = v.uses_rt;
        bus.id_rs_data  = v.rsd;
        bus.id_rt_data  = v.rtd;
        bus.id_imm      = v.imm;
        bus.id_ctrl     = v.ctrl;
        bus.id_valid    = v.valid;
    endtask

    task automatic chk_ex(input string p, input id_t e, input logic [15:0] bub, input logic [15:0] fl);
        chk({p, ".ex_rs"},      32'(bus.ex_rs),      32'(e.rs));
        chk({p, ".ex_rt"},      32'(bus.ex_rt),      32'(e.rt));
        chk({p, ".ex_rd"},      32'(bus.ex_rd),      32'(e.rd));
        chk({p, ".ex_rs_data"}, bus.ex_rs_data,      e.rsd);
        chk({p, ".ex_rt_data"}, bus.ex_rt_data,      e.rtd);
        chk({p, ".ex_imm"},     bus.ex_imm,          e.imm);
        chk({p, ".ex_ctrl"},    32'(bus.ex_ctrl),    32'(e.ctrl));
        chk({p, ".ex_valid"},   32'(bus.ex_valid),   32'(e.valid));
        chk({p, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(bub));
        chk({p, ".flush_cnt"},  32'(bus.flush_cnt),  32'(fl));
    endtask

    id_t  LW8, ADD8, ADDI_RT8, ADD_RT8, LW0, ADD0, JUNK, INV, INV_EX, BUB;
    vec_t vt[20];

    initial begin
        LW8      = '{5'd2, 5'd8, 5'd0,  1'b0, 32'd100, 32'd200, 32'd4, C_LW,   1'b1};
        ADD8     = '{5'd8, 5'd3, 5'd9,  1'b1, 32'd11,  32'd33,  32'd0, C_ADD,  1'b1};
        ADDI_RT8 = '{5'd4, 5'd8, 5'd0,  1'b0, 32'd5,   32'd6,   32'd7, C_ADDI, 1'b1};
        ADD_RT8  = '{5'd4, 5'd8, 5'd10, 1'b1, 32'd5,   32'd6,   32'd0, C_ADD,  1'b1};
        LW0      = '{5'd2, 5'd0, 5'd0,  1'b0, 32'd100, 32'd200, 32'd4, C_LW,   1'b1};
        ADD0     = '{5'd0, 5'd0, 5'd9,  1'b1, 32'd0,   32'd0,   32'd0, C_ADD,  1'b1};
        JUNK     = '{5'd8, 5'd8, 5'd8,  1'b1, 32'hdead, 32'hbeef, 32'h1234, C_LW, 1'b0};
        INV      = '{5'd5, 5'd6, 5'd7,  1'b0, 32'd1,   32'd2,   32'd3, C_ADD,  1'b0};
        INV_EX   = '{5'd5, 5'd6, 5'd7,  1'b0, 32'd1,   32'd2,   32'd3, 9'd0,   1'b0};
        BUB      = '{5'd0, 5'd0, 5'd0,  1'b0, 32'd0,   32'd0,   32'd0, 9'd0,   1'b0};

        //        rst   flush mw    in        stall ex        bub    fl
        vt[0]  = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd0, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, ADD8,     1'b1, BUB,      16'd1, 16'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, ADD8,     1'b0, ADD8,     16'd1, 16'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd1, 16'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, ADDI_RT8, 1'b0, ADDI_RT8, 16'd1, 16'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd1, 16'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, ADD_RT8,  1'b1, BUB,      16'd2, 16'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, LW0,      1'b0, LW0,      16'd2, 16'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, ADD0,     1'b0, ADD0,     16'd2, 16'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd2, 16'd0};
        vt[10] = '{1'b0, 1'b1, 1'b0, ADD8,     1'b0, BUB,      16'd2, 16'd1};
        vt[11] = '{1'b0, 1'b1, 1'b0, JUNK,     1'b0, BUB,      16'd2, 16'd1};
        vt[12] = '{1'b0, 1'b0, 1'b0, INV,      1'b0, INV_EX,   16'd2, 16'd1};
        vt[13] = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd2, 16'd1};
        vt[14] = '{1'b0, 1'b0, 1'b1, ADD8,     1'b0, LW8,      16'd2, 16'd1};
        vt[15] = '{1'b0, 1'b0, 1'b1, ADD8,     1'b0, LW8,      16'd2, 16'd1};
        vt[16] = '{1'b0, 1'b1, 1'b1, ADD8,     1'b0, LW8,      16'd2, 16'd1};
        vt[17] = '{1'b0, 1'b0, 1'b0, ADD8,     1'b1, BUB,      16'd3, 16'd1};
        vt[18] = '{1'b0, 1'b0, 1'b0, LW8,      1'b0, LW8,      16'd3, 16'd1};
        vt[19] = '{1'b1, 1'b0, 1'b1, ADD8,     1'b0, BUB,      16'd0, 16'd0};

        // reset with junk on the decode side
        drive(1'b1, 1'b1, 1'b0, JUNK);
        bus.id_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", 32'(bus.stall), 32'd0);
        chk_ex("reset", BUB, 16'd0, 16'd0);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].flush, vt[i].mw, vt[i].in);
            #1;
            chk($sformatf("v%0d.stall", i), 32'(bus.stall), 32'(vt[i].stall));
            @(posedge clk);
            #1;
            chk_ex($sformatf("v%0d", i), vt[i].ex, vt[i].bub, vt[i].fl);
        end

        // 20 load-use pairs: wide counter tracks, 4-bit counter pins at 15
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, LW8);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 1'b0, ADD8);
            @(posedge clk); #1;
        end
        chk("sat.bub_wide",   32'(bus.bubble_cnt),   32'd20);
        chk("sat.bub_narrow", 32'(bus_s.bubble_cnt), 32'd15);
        chk("sat.fl_wide",    32'(bus.flush_cnt),    32'd0);

        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 1'b0, ADD8);
            @(posedge clk); #1;
        end
        chk("sat.fl_wide",     32'(bus.flush_cnt),    32'd20);
        chk("sat.fl_narrow",   32'(bus_s.flush_cnt),  32'd15);
        chk("sat.bub_narrow2", 32'(bus_s.bubble_cnt), 32'd15);
        chk("sat.ex_valid",    32'(bus.ex_valid),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
